// File: rtl/sobel_sequencer.sv
// Sobel datapath sequencer: walks the image band by band and word column by word column,
// issuing SRAM reads, pipeline strobes, the refill request and the end-of-frame pulse.
//
// state | meaning
// IDLE  | waiting for start_en
// READ  | 4 SRAM reads, one per row of the 4-row window (k = 0..3)
// POPW  | lets the last read data land in the buffer
// SHIFT | 4 shifter/hold advances, then step to the next column or band
// DRAIN | strobes off while the delayed pipeline enables flush
// DONE  | one-cycle frame_done pulse
module sobel_sequencer #(
  parameter int W_WORDS     = 64,
  parameter int LINES       = 512,
  parameter int ADDR_W      = 20,
  parameter int REFILL_BAND = 204,
  parameter int DRAIN_CYC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pop_buffer_en,
  output logic              shift_en,
  output logic              hold_en,
  output logic              mult_en,
  output logic              mag_dir_en,
  output logic              out_en,
  output logic              get_next,
  output logic              busy,
  output logic              frame_done
);

  localparam int BANDS  = (LINES - 2) / 2;
  localparam int BAND_W = $clog2(BANDS + 1);
  localparam int COL_W  = $clog2(W_WORDS + 1);
  localparam int TMR_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_POPW, S_SHIFT, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BAND_W-1:0]  band_q, band_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [1:0]         k_q, k_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               pop_q, pop_d;
  logic [2:0]         hold_dly_q, hold_dly_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      band_q     <= '0;
      col_q      <= '0;
      k_q        <= '0;
      tmr_q      <= '0;
      pop_q      <= 1'b0;
      hold_dly_q <= '0;
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      col_q      <= col_d;
      k_q        <= k_d;
      tmr_q      <= tmr_d;
      pop_q      <= pop_d;
      hold_dly_q <= hold_dly_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    col_d      = col_q;
    k_d        = k_q;
    tmr_d      = tmr_q;
    rd_en      = 1'b0;
    shift_en   = 1'b0;
    hold_en    = 1'b0;
    get_next   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_en) begin
          state_d = S_READ;
          band_d  = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      S_READ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        // Out-of-range REFILL_BAND simply never matches, so no pulse is issued.
        get_next = (k_q == 2'd0) && (col_q == '0) && (int'(band_q) == REFILL_BAND);
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_POPW;
      end
      S_POPW: begin
        busy    = 1'b1;
        tmr_d   = TMR_W'(3);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        hold_en  = 1'b1;
        tmr_d    = tmr_q - TMR_W'(1);
        if (tmr_q == '0) begin
          if (int'(col_q) < W_WORDS - 1) begin
            col_d   = col_q + COL_W'(1);
            state_d = S_READ;
          end else if (int'(band_q) < BANDS - 1) begin
            col_d   = '0;
            band_d  = band_q + BAND_W'(1);
            state_d = S_READ;
          end else begin
            col_d   = '0;
            band_d  = '0;
            tmr_d   = TMR_W'(DRAIN_CYC - 1);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy  = 1'b1;
        tmr_d = tmr_q - TMR_W'(1);
        if (tmr_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_addr    = ADDR_W'((2 * int'(band_q) + int'(k_q)) * W_WORDS + int'(col_q));
    pop_d      = rd_en;
    hold_dly_d = {hold_dly_q[1:0], hold_en};
  end

  assign pop_buffer_en = pop_q;
  assign mult_en       = hold_dly_q[0];
  assign mag_dir_en    = hold_dly_q[1];
  assign out_en        = hold_dly_q[2];

endmodule

// File: tb/tb_sobel_sequencer.sv
// Directed bench for sobel_sequencer on a reduced 16-line frame (7 bands x 64 columns,
// 4032 cycles) so whole frames fit; a second instance has an unreachable refill band.
module tb_sobel_sequencer;

  localparam int ADDR_W = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_en = 1'b0;

  logic              rd_en, pop_buffer_en, shift_en, hold_en, mult_en, mag_dir_en, out_en;
  logic              get_next, busy, frame_done;
  logic [ADDR_W-1:0] rd_addr;

  logic              b_rd_en, b_pop, b_shift, b_hold, b_mult, b_mag, b_out;
  logic              b_get_next, b_busy, b_frame_done;
  logic [ADDR_W-1:0] b_rd_addr;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sobel_sequencer #(.W_WORDS(64), .LINES(16), .ADDR_W(ADDR_W), .REFILL_BAND(3), .DRAIN_CYC(4)) dut (
    .clk(clk), .reset(reset), .start_en(start_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .pop_buffer_en(pop_buffer_en),
    .shift_en(shift_en), .hold_en(hold_en), .mult_en(mult_en),
    .mag_dir_en(mag_dir_en), .out_en(out_en), .get_next(get_next),
    .busy(busy), .frame_done(frame_done)
  );

  sobel_sequencer #(.W_WORDS(64), .LINES(16), .ADDR_W(ADDR_W), .REFILL_BAND(300), .DRAIN_CYC(4)) dut_b (
    .clk(clk), .reset(reset), .start_en(start_en),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .pop_buffer_en(b_pop),
    .shift_en(b_shift), .hold_en(b_hold), .mult_en(b_mult),
    .mag_dir_en(b_mag), .out_en(b_out), .get_next(b_get_next),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  // {rd_en, pop, shift, hold, mult, mag_dir, out, get_next, busy, frame_done}
  wire [9:0] outs = {rd_en, pop_buffer_en, shift_en, hold_en, mult_en,
                     mag_dir_en, out_en, get_next, busy, frame_done};

  task automatic test_reset();
    reset = 1'b1;
    start_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if (outs !== 10'b0) begin
        err_cnt++;
        $display("FAIL reset_outs: got %b want 0000000000", outs);
      end
    end
    reset = 1'b0;
    start_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if (rd_en !== 1'b0 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_idle: rd_en=%b busy=%b want 0 0", rd_en, busy);
      end
    end
  endtask

  task automatic test_first_step();
    logic [9:0] exp;
    logic [ADDR_W-1:0] exp_addr;
    start_en = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start_en = 1'b0;
      exp = '0;
      exp[9] = (i >= 1 && i <= 4) || (i >= 10 && i <= 13);
      exp[8] = (i >= 2 && i <= 5) || (i >= 11 && i <= 14);
      exp[7] = (i >= 6 && i <= 9);
      exp[6] = (i >= 6 && i <= 9);
      exp[5] = (i >= 7 && i <= 10);
      exp[4] = (i >= 8 && i <= 11);
      exp[3] = (i >= 9 && i <= 12);
      exp[1] = 1'b1;
      vec_cnt++;
      if (outs !== exp) begin
        err_cnt++;
        $display("FAIL first_step_strobes c%0d: got %b want %b", i, outs, exp);
      end
      if (exp[9]) begin
        exp_addr = (i <= 4) ? ADDR_W'((i - 1) * 64) : ADDR_W'((i - 10) * 64 + 1);
        vec_cnt++;
        if (rd_addr !== exp_addr) begin
          err_cnt++;
          $display("FAIL first_step_addr c%0d: got %0d want %0d", i, rd_addr, exp_addr);
        end
      end
    end
  endtask

  task automatic test_band_wrap();
    int guard = 0;
    logic exp_rd;
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clk);
    while (!(rd_en === 1'b1 && rd_addr === ADDR_W'(63)) && guard < 700) begin
      @(negedge clk);
      guard++;
    end
    vec_cnt++;
    if (guard >= 700) begin
      err_cnt++;
      $display("FAIL band_wrap_timeout: got no read of addr 63 want one within 700 cycles");
    end else begin
      for (int j = 0; j <= 12; j++) begin
        if (j > 0) @(negedge clk);
        exp_rd = (j <= 3) || (j >= 9);
        exp_addr = (j <= 3) ? ADDR_W'(63 + 64 * j) : ADDR_W'(128 + 64 * (j - 9));
        vec_cnt++;
        if (rd_en !== exp_rd || (exp_rd && rd_addr !== exp_addr)) begin
          err_cnt++;
          $display("FAIL band_wrap c%0d: got rd_en=%b addr=%0d want rd_en=%b addr=%0d",
                   j, rd_en, rd_addr, exp_rd, exp_addr);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int gn_cnt = 0, gnb_cnt = 0, fd_cnt = 0, fd_i = -1, last_out = -1;
    logic [ADDR_W-1:0] gn_addr = '0, last_addr = '0, addr_after = '1;
    logic busy_done = 1'b0, busy_after = 1'b1, rd_after = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_en = 1'b1;
    for (int i = 1; i <= 4039; i++) begin
      @(negedge clk);
      if (get_next) begin gn_cnt++; gn_addr = rd_addr; end
      if (b_get_next) gnb_cnt++;
      if (i <= 4032 && rd_en) last_addr = rd_addr;
      if (out_en && i <= 4036) last_out = i;
      if (frame_done) begin fd_cnt++; fd_i = i; end
      if (i == 4037) busy_done = busy;
      if (i == 4038) busy_after = busy;
      if (i == 4039) begin rd_after = rd_en; addr_after = rd_addr; end
    end
    start_en = 1'b0;
    vec_cnt++;
    if (gn_cnt != 1 || gn_addr !== ADDR_W'(384)) begin
      err_cnt++;
      $display("FAIL get_next: got %0d pulses addr %0d want 1 pulse addr 384", gn_cnt, gn_addr);
    end
    vec_cnt++;
    if (gnb_cnt != 0) begin
      err_cnt++;
      $display("FAIL get_next_off: got %0d pulses want 0", gnb_cnt);
    end
    vec_cnt++;
    if (last_addr !== ADDR_W'(1023)) begin
      err_cnt++;
      $display("FAIL last_addr: got %0d want 1023", last_addr);
    end
    vec_cnt++;
    if (last_out != 4035) begin
      err_cnt++;
      $display("FAIL last_out_en: got cycle %0d want 4035", last_out);
    end
    vec_cnt++;
    if (fd_cnt != 1 || fd_i != 4037 || busy_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL frame_done: got %0d pulses at %0d busy=%b want 1 at 4037 busy=1",
               fd_cnt, fd_i, busy_done);
    end
    vec_cnt++;
    if (busy_after !== 1'b0) begin
      err_cnt++;
      $display("FAIL busy_low: got %b want 0 at 4038", busy_after);
    end
    vec_cnt++;
    if (rd_after !== 1'b1 || addr_after !== '0) begin
      err_cnt++;
      $display("FAIL back_to_back: got rd_en=%b addr=%0d want 1 0", rd_after, addr_after);
    end
  endtask

  task automatic test_abort();
    int fd_cnt = 0;
    reset = 1'b1;
    start_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_en = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (i == 1) start_en = 1'b0;
      if (frame_done) fd_cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (outs !== 10'b0) begin
      err_cnt++;
      $display("FAIL abort_outs: got %b want 0000000000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done || rd_en || get_next) fd_cnt++;
    end
    vec_cnt++;
    if (fd_cnt != 0) begin
      err_cnt++;
      $display("FAIL abort_quiet: got %0d stray pulses want 0", fd_cnt);
    end
    start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    vec_cnt++;
    if (rd_en !== 1'b1 || rd_addr !== '0) begin
      err_cnt++;
      $display("FAIL abort_restart0: got rd_en=%b addr=%0d want 1 0", rd_en, rd_addr);
    end
    @(negedge clk);
    vec_cnt++;
    if (rd_en !== 1'b1 || rd_addr !== ADDR_W'(64)) begin
      err_cnt++;
      $display("FAIL abort_restart1: got rd_en=%b addr=%0d want 1 64", rd_en, rd_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_band_wrap();
    test_full_frame();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sobel_sequencer.md
Name: sobel_sequencer

Overview:
- Central controller for the Sobel datapath: buffer, shifter, four hold blocks, multiplier, magnitude/direction and output blocks.
- Replaces free-running count-compare enable generation with an explicit FSM.
- Walks a 512x512 8-bit image stored as 64-bit words (8 pixels per word) in the source SRAM, one 2-row band and one word column at a time.
- Drives read address, per-stage enables and the SRAM refill request; reports frame completion.

Parameters:
- W_WORDS, 64, words per image line.
- LINES, 512, image lines.
- ADDR_W, 20, read address width.
- REFILL_BAND, 204, band index whose entry triggers the get_next pulse (about 4/5 of the frame).
- DRAIN_CYC, 4, flush cycles after the last shift.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_en  in  1  frame start request, level-sampled in IDLE.
- rd_en  out  1  source SRAM read strobe (read latency 1 cycle).
- rd_addr  out  ADDR_W  source SRAM word address.
- pop_buffer_en  out  1  buffer block load strobe.
- shift_en  out  1  shifter advance (16 bits per pulse).
- hold_en  out  1  hold-block capture.
- mult_en  out  1  multiplier stage enable.
- mag_dir_en  out  1  magnitude and direction stage enable.
- out_en  out  1  output block write enable.
- get_next  out  1  one-cycle request to refill the source SRAM.
- busy  out  1  high from first READ through DONE.
- frame_done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, band/col/k counters and the delay registers clear. Reset mid-frame aborts immediately; no get_next or frame_done is issued.
- Counters:
  - band 0..(LINES-2)/2-1 = 0..254.
  - col 0..W_WORDS-1.
  - k 0..3 (row within the 4-row window).
- Address: rd_addr = (2*band + k)*W_WORDS + col, computed in ADDR_W bits. The maximum is 32767, so there is no overflow.
- States:
  - IDLE: busy=0. If start_en=1 at a clock edge, go to READ with band=col=k=0.
  - READ (4 cycles): rd_en=1 with rd_addr for k=0..3; k increments each cycle. After k=3, go to POPW.
  - POPW (1 cycle): lets the last pop complete. Go to SHIFT.
  - SHIFT (4 cycles): shift_en=1 and hold_en=1 every cycle. In the 4th cycle:
    - if col<W_WORDS-1: col++, go to READ;
    - else col=0, band++, go to READ;
    - after the final step (band=254, col=63): go to DRAIN.
  - DRAIN (DRAIN_CYC cycles): all strobes are 0, delay registers keep shifting. Go to DONE.
  - DONE (1 cycle): frame_done=1, busy=1. Go to IDLE.
- Step length: 9 cycles. A frame is 255*64 = 16320 steps, i.e. 146880 cycles.
- Derived strobes (registered delays):
  - pop_buffer_en = rd_en delayed 1.
  - mult_en = hold_en delayed 1.
  - mag_dir_en = hold_en delayed 2.
  - out_en = hold_en delayed 3.
  - These delays run in every state except under reset.
- get_next:
  - Exactly one pulse per frame, in the first READ cycle of band REFILL_BAND (col=0, k=0).
  - If REFILL_BAND>254, it never fires.
- start_en: ignored while busy=1. If start_en is still high in IDLE after DONE, a new frame starts in the next cycle (back-to-back frames).
- Simultaneous reset and start_en: reset wins.

Test Plan:
- Reset values: assert reset 3 cycles with start_en=1 -> all outputs 0, busy=0; no rd_en until reset is deasserted and start_en is sampled.
- First-step timing: start_en at edge N:
  - rd_en cycles N+1..N+4 with rd_addr 0,64,128,192;
  - pop_buffer_en N+2..N+5;
  - shift_en/hold_en N+6..N+9;
  - mult_en N+7..N+10; mag_dir_en N+8..N+11; out_en N+9..N+12;
  - next rd_en at N+10 with rd_addr 1.
- Band wrap: at band=0, col=63 (addresses 63,127,191,255), the next READ gives addresses 128,192,256,320 (band 1, col 0).
- get_next: run a full frame -> exactly one pulse, in the cycle rd_addr=408*64=26112 with k=0; a run with REFILL_BAND=300 -> zero pulses.
- Frame end: last rd_addr=32767; last out_en at N+146883; frame_done only at N+146885; busy low at N+146886; start_en held high -> rd_en again at N+146887 with rd_addr 0.
- Abort: reset asserted at edge N+5000 -> all strobes 0 from N+5001; no frame_done; a fresh start restarts from rd_addr 0.
